input_debouncer: RTL and testbench

//  Conditions raw board inputs (switches/push-buttons) before they drive the logic-gate

---
 rtl/debounce_pkg.sv | 10 +
 rtl/input_debouncer_if.sv | 12 +
 rtl/debounce_cell.sv | 84 ++++++++
 rtl/input_debouncer.sv | 26 ++
 tb/tb_input_debouncer.sv | 133 +++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the input debouncer slice.
package debounce_pkg;

    localparam int DEFAULT_CNT_MAX = 500000;

    function automatic int cnt_width(input int cnt_max);
        return $clog2(cnt_max + 1);
    endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Channel bundle between raw board inputs and the debounced level/edge outputs.
interface input_debouncer_if #(
    parameter int N_IN = 2
);
    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] level_out;
    logic [N_IN-1:0] rise_out;
    logic [N_IN-1:0] fall_out;

    modport master (output raw_in, input level_out, input rise_out, input fall_out);
    modport slave  (input raw_in, output level_out, output rise_out, output fall_out);
endinterface

// File: rtl/debounce_cell.sv
// One debouncer channel: 2-flop synchronizer, stability counter, level register, edge pulses.
// Edge pulse registers exist only when DEBOUNCER_EDGE_EN is defined; otherwise pulses are tied low.
module debounce_cell
    import debounce_pkg::*;
#(
    parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    localparam int CW = cnt_width(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          fire;

    always_comb begin
        s1_d    = raw_in;
        s2_d    = s1_q;
        cnt_d   = '0;
        level_d = level_q;
        fire    = 1'b0;
        // Any sample matching the current level discards the mismatch streak.
        if (s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                fire    = 1'b1;
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_out = level_q;

`ifdef DEBOUNCER_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        rise_d = fire & s2_q;
        fall_d = fire & ~s2_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_out = rise_q;
    assign fall_out = fall_q;
`else
    assign rise_out = 1'b0;
    assign fall_out = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Top: N_IN independent debounce channels; optional edge pulses via DEBOUNCER_EDGE_EN.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int N_IN    = 2,
    parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
    input logic         clock,
    input logic         reset,
    input_debouncer_if.slave dbi
);

    for (genvar i = 0; i < N_IN; i++) begin : g_cell
        debounce_cell #(
            .CNT_MAX (CNT_MAX)
        ) u_cell (
            .clock     (clock),
            .reset     (reset),
            .raw_in    (dbi.raw_in[i]),
            .level_out (dbi.level_out[i]),
            .rise_out  (dbi.rise_out[i]),
            .fall_out  (dbi.fall_out[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with N_IN=2, CNT_MAX=4; pulse expectations follow DEBOUNCER_EDGE_EN.
module tb_input_debouncer;

`ifdef DEBOUNCER_EDGE_EN
    localparam logic [1:0] EDGE_MASK = 2'b11;
`else
    localparam logic [1:0] EDGE_MASK = 2'b00;
`endif

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    input_debouncer_if #(.N_IN(2)) dbi ();

    input_debouncer #(
        .N_IN    (2),
        .CNT_MAX (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .dbi   (dbi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] lvl, input logic [1:0] rise,
                           input logic [1:0] fall);
        chk({tag, ".level"}, dbi.level_out, lvl);
        chk({tag, ".rise"}, dbi.rise_out, rise & EDGE_MASK);
        chk({tag, ".fall"}, dbi.fall_out, fall & EDGE_MASK);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        dbi.raw_in = 2'b00;
        step(2);
        chk_all("reset_state", 2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        step(1);
        chk_all("idle", 2'b00, 2'b00, 2'b00);

        // Short glitch on channel 0: high for 3 samples only.
        dbi.raw_in = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk_all($sformatf("glitch_k%0d", k), 2'b00, 2'b00, 2'b00);
            if (k == 3) dbi.raw_in = 2'b00;
        end

        // Clean 0->1 on channel 0.
        dbi.raw_in = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            chk_all($sformatf("rise_k%0d", k), (k >= 6) ? 2'b01 : 2'b00,
                    (k == 6) ? 2'b01 : 2'b00, 2'b00);
        end

        // Channel 0 falls while channel 1 rises two cycles later.
        dbi.raw_in = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk_all($sformatf("fall_k%0d", k), {k >= 8, k < 6},
                    {k == 8, 1'b0}, {1'b0, k == 6});
            if (k == 2) dbi.raw_in = 2'b10;
        end

        // Bounce 1,0,1,0 on channel 0 then steady 1.
        for (int b = 0; b < 4; b++) begin
            dbi.raw_in[0] = (b % 2 == 0);
            step(1);
            chk_all($sformatf("bounce_b%0d", b), 2'b10, 2'b00, 2'b00);
        end
        dbi.raw_in[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk_all($sformatf("bounce_k%0d", k), {1'b1, k == 6}, {1'b0, k == 6}, 2'b00);
        end

        // Reset mid-count while both levels are high.
        dbi.raw_in = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk_all($sformatf("precount_k%0d", k), 2'b11, 2'b00, 2'b00);
        end
        reset = 1'b1;
        #1;
        chk_all("reset_async", 2'b00, 2'b00, 2'b00);
        step(1);
        chk_all("reset_hold1", 2'b00, 2'b00, 2'b00);
        step(1);
        chk_all("reset_hold2", 2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        step(1);
        chk_all("post_reset", 2'b00, 2'b00, 2'b00);

        // Short reset pulse at cycle 3 of a count: full run needed afterwards.
        dbi.raw_in = 2'b01;
        step(3);
        chk_all("prepulse", 2'b00, 2'b00, 2'b00);
        reset = 1'b1;
        #2;
        chk_all("pulse_reset", 2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            chk_all($sformatf("restart_k%0d", k), (k >= 6) ? 2'b01 : 2'b00,
                    (k == 6) ? 2'b01 : 2'b00, 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
